timer_tick_master: RTL and testbench

Avalon-MM initiator that owns the interval timer's s1 slave port. It programs the timer's control register after reset and services each timeout interrupt: read status, confirm the timeout bit, clear it. From the confirmed timeouts (one per second at the timer's fixed period) it maintains a 24-hour time-of-day count and raises the alarm output for the alarm clock design.

---
 rtl/timer_tick_master_if.sv | 20 ++
 rtl/timer_tick_master.sv | 171 +++++++++++++++++
 tb/tb_timer_tick_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_tick_master_if.sv
// Avalon-MM link between the tick master and the interval timer's s1 slave port.
// The timer registers irq and readdata; the master owns address, chipselect and the write strobe.
interface timer_tick_master_if;
   logic        irq;
   logic [15:0] readdata;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;

   modport master (
      input  irq, readdata,
      output address, chipselect, write_n, writedata
   );

   modport slave (
      output irq, readdata,
      input  address, chipselect, write_n, writedata
   );
endinterface

// File: rtl/timer_tick_master.sv
// Interval-timer service master: programs the timer, acknowledges each timeout and
// keeps a 24-hour time of day with a latched alarm.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// INIT_WR   | one-cycle write of CTRL_INIT to timer control after reset
// IDLE      | bus idle, waiting for irq
// RD_STATUS | status read issued (address 0)
// RD_WAIT   | read held; readdata[0] decides timeout vs. spurious irq
// CLR_WR    | write 0 to status to clear the timeout bit
// UPDATE    | advance time, pulse tick, evaluate alarm
module timer_tick_master #(
   parameter logic [15:0] CTRL_INIT = 16'h0001,
   parameter int          HOURS_MAX = 23
) (
   input  logic                 clk,
   input  logic                 reset_n,
   timer_tick_master_if.master  bus,
   input  logic                 set_time,
   input  logic [4:0]           set_hour,
   input  logic [5:0]           set_min,
   input  logic                 alarm_en,
   input  logic [4:0]           alarm_hour,
   input  logic [5:0]           alarm_min,
   input  logic                 alarm_ack,
   output logic [4:0]           hours,
   output logic [5:0]           minutes,
   output logic [5:0]           seconds,
   output logic                 tick,
   output logic                 alarm
);

   localparam logic [4:0] HMAX = HOURS_MAX[4:0];

   typedef enum logic [2:0] {
      INIT_WR,
      IDLE,
      RD_STATUS,
      RD_WAIT,
      CLR_WR,
      UPDATE
   } state_t;

   state_t state;
   state_t next_state;
   state_t drive_state;

   logic        cs_d;
   logic        wn_d;
   logic [2:0]  addr_d;
   logic [15:0] wd_d;

   logic [5:0]  sec_inc;
   logic [5:0]  min_inc;
   logic [4:0]  hr_inc;
   logic        load_ok;
   logic        alarm_hit;
   logic        unused_rd;

   assign unused_rd = ^bus.readdata[15:1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= INIT_WR;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         INIT_WR:   next_state = IDLE;
         IDLE:      next_state = bus.irq ? RD_STATUS : IDLE;
         RD_STATUS: next_state = RD_WAIT;
         RD_WAIT:   next_state = bus.readdata[0] ? CLR_WR : IDLE;
         CLR_WR:    next_state = UPDATE;
         UPDATE:    next_state = IDLE;
         default:   next_state = INIT_WR;
      endcase
   end

   // Bus registers follow the state being entered, so the drive lines up with the state;
   // INIT_WR is the reset state and therefore drives from itself on the first edge.
   always_comb begin
      drive_state = (state == INIT_WR) ? INIT_WR : next_state;
      cs_d        = 1'b0;
      wn_d        = 1'b1;
      addr_d      = 3'd0;
      wd_d        = 16'h0000;
      case (drive_state)
         INIT_WR: begin
            cs_d   = 1'b1;
            wn_d   = 1'b0;
            addr_d = 3'd1;
            wd_d   = CTRL_INIT;
         end
         RD_STATUS, RD_WAIT: begin
            cs_d = 1'b1;
         end
         CLR_WR: begin
            cs_d = 1'b1;
            wn_d = 1'b0;
         end
         default: begin
            cs_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.chipselect <= 1'b0;
         bus.write_n    <= 1'b1;
         bus.address    <= 3'd0;
         bus.writedata  <= 16'h0000;
      end else begin
         bus.chipselect <= cs_d;
         bus.write_n    <= wn_d;
         bus.address    <= addr_d;
         bus.writedata  <= wd_d;
      end
   end

   always_comb begin
      sec_inc = seconds + 6'd1;
      min_inc = minutes;
      hr_inc  = hours;
      if (seconds == 6'd59) begin
         sec_inc = 6'd0;
         if (minutes == 6'd59) begin
            min_inc = 6'd0;
            hr_inc  = (hours == HMAX) ? 5'd0 : hours + 5'd1;
         end else begin
            min_inc = minutes + 6'd1;
         end
      end
   end

   assign load_ok   = set_time && (set_hour <= HMAX) && (set_min <= 6'd59);
   // A load in UPDATE discards the increment, so it cannot raise the alarm either.
   assign alarm_hit = (state == UPDATE) && !load_ok && alarm_en &&
                      (hr_inc == alarm_hour) && (min_inc == alarm_min) && (sec_inc == 6'd0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hours   <= 5'd0;
         minutes <= 6'd0;
         seconds <= 6'd0;
         tick    <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         tick <= (state == UPDATE);
         if (load_ok) begin
            hours   <= set_hour;
            minutes <= set_min;
            seconds <= 6'd0;
         end else if (state == UPDATE) begin
            hours   <= hr_inc;
            minutes <= min_inc;
            seconds <= sec_inc;
         end
         if (alarm_hit) begin
            alarm <= 1'b1;
         end else if (alarm_ack || !alarm_en) begin
            alarm <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_timer_tick_master.sv
// Directed bench for timer_tick_master with a small behavioural interval-timer slave.
module tb_timer_tick_master;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       set_time;
   logic [4:0] set_hour;
   logic [5:0] set_min;
   logic       alarm_en;
   logic [4:0] alarm_hour;
   logic [5:0] alarm_min;
   logic       alarm_ack;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       tick;
   logic       alarm;

   int total = 0;
   int bad   = 0;
   int ctrl_wr = 0;
   int clr_wr  = 0;
   int tick_cnt = 0;
   int ctrl_base;
   int clr_base;
   int tick_base;

   logic        fire;
   logic        spur;
   logic        to_bit;
   logic [15:0] ctrl;

   timer_tick_master_if bus ();

   timer_tick_master #(.CTRL_INIT(16'h0001), .HOURS_MAX(23)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .set_time   (set_time),
      .set_hour   (set_hour),
      .set_min    (set_min),
      .alarm_en   (alarm_en),
      .alarm_hour (alarm_hour),
      .alarm_min  (alarm_min),
      .alarm_ack  (alarm_ack),
      .hours      (hours),
      .minutes    (minutes),
      .seconds    (seconds),
      .tick       (tick),
      .alarm      (alarm)
   );

   always #5 clk = ~clk;

   // Interval timer slave: status bit0 = timeout, control bit0 = irq enable.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_bit       <= 1'b0;
         ctrl         <= 16'h0000;
         bus.readdata <= 16'h0000;
         bus.irq      <= 1'b0;
      end else begin
         if (fire) to_bit <= 1'b1;
         if (bus.chipselect && !bus.write_n) begin
            if (bus.address == 3'd1) ctrl <= bus.writedata;
            else if (bus.address == 3'd0) to_bit <= 1'b0;
         end
         if (bus.chipselect && bus.address == 3'd0) bus.readdata <= {15'd0, to_bit};
         else if (bus.chipselect && bus.address == 3'd1) bus.readdata <= ctrl;
         else bus.readdata <= 16'h0000;
         bus.irq <= (to_bit & ctrl[0]) | spur;
      end
   end

   always @(posedge clk) begin
      if (reset_n && bus.chipselect && !bus.write_n) begin
         if (bus.address == 3'd1) ctrl_wr++;
         else clr_wr++;
      end
      if (tick) tick_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fire_irq();
      fire = 1'b1;
      @(negedge clk);
      fire = 1'b0;
   endtask

   task automatic do_tick();
      int n;
      fire_irq();
      n = 0;
      while (tick !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("tick_seen", {31'd0, tick}, 32'd1);
      @(negedge clk);
   endtask

   task automatic load_time(input logic [4:0] h, input logic [5:0] m);
      set_hour = h;
      set_min  = m;
      set_time = 1'b1;
      @(negedge clk);
      set_time = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; set_time = 1'b0; set_hour = 5'd0; set_min = 6'd0;
      alarm_en = 1'b0; alarm_hour = 5'd0; alarm_min = 6'd0; alarm_ack = 1'b0;
      fire = 1'b0; spur = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_cs",   {31'd0, bus.chipselect}, 32'd0);
      check("rst_wn",   {31'd0, bus.write_n}, 32'd1);
      check("rst_addr", {29'd0, bus.address}, 32'd0);
      check("rst_wd",   {16'd0, bus.writedata}, 32'd0);
      check("rst_time", {15'd0, hours, minutes, seconds}, 32'd0);
      check("rst_tick_alarm", {30'd0, tick, alarm}, 32'd0);

      // control write right after reset release
      reset_n = 1'b1;
      @(negedge clk);
      check("init_cs",   {31'd0, bus.chipselect}, 32'd1);
      check("init_wn",   {31'd0, bus.write_n}, 32'd0);
      check("init_addr", {29'd0, bus.address}, 32'd1);
      check("init_wd",   {16'd0, bus.writedata}, 32'h0001);
      @(negedge clk);
      check("init_done_cs", {31'd0, bus.chipselect}, 32'd0);
      check("init_done_wn", {31'd0, bus.write_n}, 32'd1);
      check("ctrl_prog", {16'd0, ctrl}, 32'h0001);
      check("ctrl_wr_cnt", ctrl_wr, 32'd1);

      // one serviced timeout, cycle by cycle
      fire_irq();
      @(negedge clk);
      @(negedge clk);
      check("e0_rd", {29'd0, bus.chipselect, bus.write_n, bus.address[0]}, 32'b110);
      @(negedge clk);
      check("e1_rd", {29'd0, bus.chipselect, bus.write_n, bus.address[0]}, 32'b110);
      check("e1_rdata", {16'd0, bus.readdata}, 32'h0001);
      @(negedge clk);
      check("e2_clr", {29'd0, bus.chipselect, bus.write_n, bus.address[0]}, 32'b100);
      check("e2_wd", {16'd0, bus.writedata}, 32'd0);
      @(negedge clk);
      check("e3_idle", {30'd0, bus.chipselect, tick}, 32'b00);
      @(negedge clk);
      check("e4_tick", {31'd0, tick}, 32'd1);
      check("e4_sec", {26'd0, seconds}, 32'd1);
      check("e4_cs", {31'd0, bus.chipselect}, 32'd0);
      @(negedge clk);
      check("e5_tick_low", {31'd0, tick}, 32'd0);
      @(negedge clk);
      check("no_double", {31'd0, bus.chipselect}, 32'd0);
      check("clr_wr_cnt", clr_wr, 32'd1);

      // 23:59 wraps to 00:00:00 after 60 ticks
      load_time(5'd23, 6'd59);
      check("set_2359", {15'd0, hours, minutes, seconds}, {15'd0, 5'd23, 6'd59, 6'd0});
      tick_base = tick_cnt;
      for (int i = 0; i < 59; i++) do_tick();
      check("t_235959", {15'd0, hours, minutes, seconds}, {15'd0, 5'd23, 6'd59, 6'd59});
      do_tick();
      check("t_wrap", {15'd0, hours, minutes, seconds}, 32'd0);
      check("tick_pulses", tick_cnt - tick_base, 32'd60);

      // alarm at 07:30:00
      alarm_en = 1'b1; alarm_hour = 5'd7; alarm_min = 6'd30;
      load_time(5'd7, 6'd29);
      check("alarm_after_load", {31'd0, alarm}, 32'd0);
      for (int i = 0; i < 59; i++) do_tick();
      check("t_072959", {15'd0, hours, minutes, seconds}, {15'd0, 5'd7, 6'd29, 6'd59});
      check("alarm_early", {31'd0, alarm}, 32'd0);
      do_tick();
      check("t_073000", {15'd0, hours, minutes, seconds}, {15'd0, 5'd7, 6'd30, 6'd0});
      check("alarm_set", {31'd0, alarm}, 32'd1);
      alarm_ack = 1'b1;
      @(negedge clk);
      alarm_ack = 1'b0;
      check("alarm_ack", {31'd0, alarm}, 32'd0);
      load_time(5'd7, 6'd30);
      @(negedge clk);
      check("alarm_not_by_load", {31'd0, alarm}, 32'd0);

      // spurious interrupt: status read only
      clr_base = clr_wr; tick_base = tick_cnt;
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      @(negedge clk);
      check("sp_e0", {30'd0, bus.chipselect, bus.write_n}, 32'b11);
      @(negedge clk);
      check("sp_e1", {30'd0, bus.chipselect, bus.write_n}, 32'b11);
      @(negedge clk);
      check("sp_e2_idle", {30'd0, bus.chipselect, bus.write_n}, 32'b01);
      repeat (4) @(negedge clk);
      check("sp_no_write", clr_wr - clr_base, 32'd0);
      check("sp_no_tick", tick_cnt - tick_base, 32'd0);
      check("sp_time", {15'd0, hours, minutes, seconds}, {15'd0, 5'd7, 6'd30, 6'd0});

      // reset during the clear write
      ctrl_base = ctrl_wr;
      fire_irq();
      repeat (4) @(negedge clk);
      check("pre_rst_clr", {30'd0, bus.chipselect, bus.write_n}, 32'b10);
      reset_n = 1'b0;
      #1;
      check("rst_mid_bus", {30'd0, bus.chipselect, bus.write_n}, 32'b01);
      check("rst_mid_time", {15'd0, hours, minutes, seconds}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("reinit_wr", {28'd0, bus.chipselect, bus.write_n, bus.address[1:0]}, 32'b1001);
      @(negedge clk);
      check("reinit_cnt", ctrl_wr - ctrl_base, 32'd1);
      load_time(5'd24, 6'd10);
      check("bad_hour_ignored", {15'd0, hours, minutes, seconds}, 32'd0);
      load_time(5'd3, 6'd60);
      check("bad_min_ignored", {15'd0, hours, minutes, seconds}, 32'd0);

      // set_time coinciding with UPDATE wins over the increment
      fire_irq();
      repeat (5) @(negedge clk);
      set_hour = 5'd5; set_min = 6'd6; set_time = 1'b1;
      @(negedge clk);
      set_time = 1'b0;
      check("upd_load_tick", {31'd0, tick}, 32'd1);
      check("upd_load_time", {15'd0, hours, minutes, seconds}, {15'd0, 5'd5, 6'd6, 6'd0});
      do_tick();
      check("after_reset_tick", {15'd0, hours, minutes, seconds}, {15'd0, 5'd5, 6'd6, 6'd1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
